divider: RTL and testbench
==========================

// Module: divider
// PURPOSE
//  Multicycle restoring unsigned divider. It is the inverse unit of the shift-add multiplier and
//  serves the DIVU instruction in the EX stage. A start pulse captures the dividend and divisor.
//  The unit then produces one quotient bit per cycle and returns {remainder, quotient} for the
//  HI/LO write-back.
// PARAMETERS
//  WIDTH   32   operand width; dataOut is 2*WIDTH
// PORTS
//  clk      in   1          rising-edge clock; single clock domain
//  reset    in   1          synchronous, active-high reset
//  Divu     in   1          start pulse; sampled only in IDLE
//  dataA    in   WIDTH      dividend; captured on the accepted start
//  dataB    in   WIDTH      divisor; captured on the accepted start
//  Div      in   1          signed-mode select (port exists only with DIVIDER_SIGNED_EN)
//  busy     out  1          high from the cycle after accept through the DONE cycle
//  done     out  1          one-cycle pulse; dataOut valid in this cycle
//  dataOut  out  2*WIDTH    {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; HI=rem, LO=quot
// BEHAVIOUR
//  - Reset (sync): state=IDLE, counter=0, busy=0, done=0, dataOut=0, all working regs=0.
//    Reset wins over every other event, including mid-RUN; the in-flight result is discarded.
//  - FSM states:
//    - IDLE: on Divu=1, capture A/B, set rem=0, quot=A, counter=0, go to RUN.
//    - RUN: perform WIDTH iterations, counter 0..WIDTH-1. When counter==WIDTH-1, go to DONE.
//    - DONE: done=1, dataOut<={rem,quot}, go to IDLE.
//  - Latency: Divu accepted at edge N -> done high in cycle N+WIDTH+1 (33 for WIDTH=32).
//    The next start is accepted no earlier than the cycle done is high.
//  - Iteration (restoring):
//    - t = {rem[WIDTH-2:0], quot[WIDTH-1]} - {1'b0, divisor}, computed WIDTH+1 bits wide.
//    - If t is non-negative: rem <= t[WIDTH-1:0] and quot <= {quot[WIDTH-2:0], 1'b1}.
//    - Otherwise: rem <= shifted rem and quot <= {quot[WIDTH-2:0], 1'b0}.
//  - Divu while busy is ignored: no restart and no error. Divu in the DONE cycle is also ignored.
//  - dataOut holds its last result until the next DONE; it is not cleared on start.
//  - Divide by zero runs the normal algorithm, giving quotient=all ones and remainder=dividend.
//    No trap is raised; the pipeline treats the result as architecturally undefined.
//  - Operand changes on dataA/dataB after accept have no effect.
// CONFIGURATION
//  - DIVIDER_SIGNED_EN defined: adds the Div input.
//    - Div=1 on accept: operands are converted to magnitudes and the sign bits are registered.
//    - In DONE, the quotient is negated when sign(A)^sign(B) is set.
//    - The remainder takes the sign of the dividend (truncating division).
//    - Div=0 gives pure unsigned behaviour; latency is unchanged.
//  - DIVIDER_SIGNED_EN undefined: there is no Div port and the unit is unsigned only.
// STRUCTURE
//  - Package divider_pkg holds:
//    - the state typedef {IDLE, RUN, DONE};
//    - DIV_WIDTH = 32;
//    - the counter width $clog2(DIV_WIDTH);
//    - the DIVU funct constant 6'd27.
//  - Sub-module div_step: combinational single restoring step.
//    - Inputs: rem, quot, divisor.
//    - Outputs: rem_next, quot_next.
//  - The top level holds the FSM, counter, operand registers and sign fix-up.
// TESTING
//  1. A=100, B=7, start -> done exactly 33 cycles later; dataOut={32'd2, 32'd14}.
//  2. A=32'hFFFFFFFF, B=1 -> dataOut={32'd0, 32'hFFFFFFFF}.
//     A=5, B=9 -> dataOut={32'd5, 32'd0}.
//  3. B=0, A=32'h1234 -> dataOut={32'h1234, 32'hFFFFFFFF}; busy/done timing is normal.
//  4. Start 100/7, then pulse Divu with 50/5 at cycle +10 -> the second start is ignored;
//     the result is {2, 14} at +33.
//  5. Start 100/7, assert reset at cycle +15 for 1 cycle -> busy=0, done=0, dataOut=0 next cycle.
//     A fresh 9/3 start afterwards gives {0, 3}.
//  6. With DIVIDER_SIGNED_EN: Div=1, A=-7, B=2 -> {32'hFFFFFFFF, 32'hFFFFFFFD} (R=-1, Q=-3).
//     A=7, B=-2 -> {32'd1, 32'hFFFFFFFD}.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the multicycle restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned DIV_WIDTH  = 32;
    localparam int unsigned DIV_CNT_W  = $clog2(DIV_WIDTH);
    localparam logic [5:0]  FUNCT_DIVU = 6'd27;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quot,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quot_next
);

    logic [W:0] w_shift;
    logic [W:0] w_t;

    // rem < divisor always holds between steps, so the top bit of w_shift never carries data.
    assign w_shift   = {rem, quot[W-1]};
    assign w_t       = w_shift - {1'b0, divisor};
    assign rem_next  = w_t[W] ? w_shift[W-1:0] : w_t[W-1:0];
    assign quot_next = {quot[W-2:0], ~w_t[W]};

endmodule

// File: rtl/divider.sv
// Multicycle restoring divider for DIVU: one quotient bit per cycle, result {rem, quot}.
// Optional signed mode (Div port, magnitude conversion and sign fix-up) under DIVIDER_SIGNED_EN.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Divu,
`ifdef DIVIDER_SIGNED_EN
    input  logic                 Div,
`endif
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dataOut
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_divisor;

    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quot_next;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_res_rem;
    logic [WIDTH-1:0]   w_res_quot;

`ifdef DIVIDER_SIGNED_EN
    logic               r_neg_q;
    logic               r_neg_r;
    logic               w_sgn_a;
    logic               w_sgn_b;

    // Signed operands are divided as magnitudes; signs are reapplied when the result is written.
    assign w_sgn_a    = Div & dataA[WIDTH-1];
    assign w_sgn_b    = Div & dataB[WIDTH-1];
    assign w_a_mag    = w_sgn_a ? (~dataA + WIDTH'(1)) : dataA;
    assign w_b_mag    = w_sgn_b ? (~dataB + WIDTH'(1)) : dataB;
    assign w_res_quot = r_neg_q ? (~r_quot + WIDTH'(1)) : r_quot;
    assign w_res_rem  = r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;
`else
    assign w_a_mag    = dataA;
    assign w_b_mag    = dataB;
    assign w_res_quot = r_quot;
    assign w_res_rem  = r_rem;
`endif

    div_step #(
        .W         (WIDTH)
    ) u_step (
        .rem       (r_rem),
        .quot      (r_quot),
        .divisor   (r_divisor),
        .rem_next  (w_rem_next),
        .quot_next (w_quot_next)
    );

    // busy stays high through the cycle done is asserted and drops on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dataOut   <= '0;
`ifdef DIVIDER_SIGNED_EN
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    busy <= Divu;
                    if (Divu) begin
                        r_rem     <= '0;
                        r_quot    <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_cnt     <= '0;
                        r_state   <= RUN;
`ifdef DIVIDER_SIGNED_EN
                        r_neg_q   <= w_sgn_a ^ w_sgn_b;
                        r_neg_r   <= w_sgn_a;
`endif
                    end
                end
                RUN: begin
                    r_rem  <= w_rem_next;
                    r_quot <= w_quot_next;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    dataOut <= {w_res_rem, w_res_quot};
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases plus random operands against an arithmetic model.
// Build with DIVIDER_SIGNED_EN defined to also exercise signed mode.
module tb_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        Divu;
`ifdef DIVIDER_SIGNED_EN
    logic        Div;
`endif
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [63:0] dataOut;

    int total = 0;
    int bad   = 0;

    divider dut (
        .clk     (clk),
        .reset   (reset),
        .Divu    (Divu),
`ifdef DIVIDER_SIGNED_EN
        .Div     (Div),
`endif
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Truncating division on magnitudes; divide-by-zero yields all-ones quotient, remainder = |A|.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic        na, nb;
        logic [31:0] ma, mb, q, r;
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? 32'(-a) : a;
        mb = nb ? 32'(-b) : b;
        if (mb == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (na ^ nb) q = 32'(-q);
        if (na)      r = 32'(-r);
        return {r, q};
    endfunction

    // Launch one division; optionally pulse Divu again at cycle 'intrude' or assert reset at 'rst_at'.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input bit sgn, input int intrude, input int rst_at);
        int cycles;
        logic [63:0] exp;
        exp = model(a, b, sgn);
        @(negedge clk);
        dataA = a;
        dataB = b;
        Divu  = 1'b1;
`ifdef DIVIDER_SIGNED_EN
        Div   = sgn;
`endif
        @(posedge clk);
        @(negedge clk);
        Divu  = 1'b0;
        dataA = $urandom;
        dataB = $urandom;
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        cycles = 0;
        do begin
            Divu = (cycles == intrude);
            if (cycles == intrude) begin
                dataA = 32'd50;
                dataB = 32'd5;
            end
            if (cycles == rst_at - 1) reset = 1'b1;
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (cycles == rst_at) begin
                reset = 1'b0;
                check({tag, "_rst_busy"}, 64'(busy), 64'd0);
                check({tag, "_rst_done"}, 64'(done), 64'd0);
                check({tag, "_rst_data"}, dataOut, 64'd0);
                return;
            end
        end while (!done && cycles < 100);
        Divu = 1'b0;
        check({tag, "_latency"}, 64'(cycles), 64'd33);
        check({tag, "_busy_done"}, 64'(busy), 64'd1);
        check({tag, "_result"}, dataOut, exp);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_hold"}, dataOut, exp);
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset = 1'b1;
        Divu  = 1'b0;
        dataA = '0;
        dataB = '0;
`ifdef DIVIDER_SIGNED_EN
        Div   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_data", dataOut, 64'd0);
        reset = 1'b0;

        check("model_100_7", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        run_div("t100_7", 32'd100, 32'd7, 1'b0, -1, -1);
        run_div("tmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, -1, -1);
        run_div("t5_9", 32'd5, 32'd9, 1'b0, -1, -1);
        run_div("tdiv0", 32'h1234, 32'd0, 1'b0, -1, -1);
        run_div("tbig", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, -1, -1);
        run_div("tintrude", 32'd100, 32'd7, 1'b0, 10, -1);
        run_div("tdone_start", 32'd100, 32'd7, 1'b0, 32, -1);
        run_div("treset", 32'd100, 32'd7, 1'b0, -1, 15);
        run_div("t9_3", 32'd9, 32'd3, 1'b0, -1, -1);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : ($urandom >> $urandom_range(0, 31));
            run_div($sformatf("rand%0d", i), ra, rb, 1'b0, -1, -1);
        end

`ifdef DIVIDER_SIGNED_EN
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, -1, -1);
        run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, -1, -1);
        run_div("s_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, -1, -1);
        run_div("s_unsigned_sel", 32'hFFFF_FFF9, 32'd2, 1'b0, -1, -1);
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (rb == 32'd0) rb = 32'd3;
            run_div($sformatf("srand%0d", i), ra, rb, 1'b1, -1, -1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
